// File: rtl/usb_linestate_gen.sv
// usb_linestate_gen: device-attach linestate source (SE0 idle, J attach, SE0 reset window, J) for speed-autodetect self-test.
// Ports: fe_clk/reset_n (async active-low); I_start/I_abort control; I_speed target speed
// (00 AUTO, 01 LS, 10 FS, 11 HS); I_wait0/1/2 durations; O_linestate {D-,D+}; O_busy, O_done, O_error status.
module usb_linestate_gen #(
    parameter int pCOUNTER_WIDTH = 24,
    parameter int pMARGIN        = 2
) (
    input  logic                      fe_clk,
    input  logic                      reset_n,
    input  logic                      I_start,
    input  logic                      I_abort,
    input  logic [1:0]                I_speed,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait0,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
    input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
    output logic [1:0]                O_linestate,
    output logic                      O_busy,
    output logic                      O_done,
    output logic                      O_error
);
    localparam int lp_w = pCOUNTER_WIDTH;
    localparam logic [1:0] lp_auto = 2'd0;
    localparam logic [1:0] lp_ls   = 2'd1;
    localparam logic [1:0] lp_hs   = 2'd3;
    localparam logic [lp_w:0]   lp_margin_x = (lp_w+1)'(pMARGIN);
    localparam logic [lp_w-1:0] lp_margin   = lp_w'(pMARGIN);
    localparam logic [lp_w-1:0] lp_one      = lp_w'(1);
    typedef enum logic [2:0] {S_IDLE, S_WAIT0, S_ATTACH, S_RESET_SE0, S_DONE} state_t;
    state_t            r_state, w_next;
    logic [lp_w-1:0]   r_cnt, w_len, w_fs_len;
    logic [1:0]        r_speed;
    logic              r_error, w_load, w_accept, w_err, w_expire;
    function automatic logic [lp_w-1:0] f_add_sat(input logic [lp_w-1:0] a);
        logic [lp_w:0] s;
        s = {1'b0, a} + lp_margin_x;
        return s[lp_w] ? '1 : s[lp_w-1:0];
    endfunction
    assign w_expire = r_cnt == '0;
    // FS reset window is shortened so the detector lands below its low threshold, never under one cycle
    assign w_fs_len = (I_wait2 > lp_margin) ? I_wait2 - lp_margin : lp_one;
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_len    = '0;
        w_accept = 1'b0;
        w_err    = 1'b0;
        if (I_abort) begin
            w_next = S_IDLE;
            w_load = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (I_start) begin
                    w_err    = I_speed == lp_auto;
                    w_accept = I_speed != lp_auto;
                    w_next   = (I_speed == lp_auto) ? r_state : S_WAIT0;
                    w_load   = 1'b1;
                    w_len    = I_wait0;
                end
                S_WAIT0: if (w_expire) begin
                    w_next = S_ATTACH;
                    w_load = 1'b1;
                    w_len  = f_add_sat(I_wait1);
                end
                S_ATTACH: if (w_expire) begin
                    w_next = (r_speed == lp_ls) ? S_DONE : S_RESET_SE0;
                    w_load = 1'b1;
                    w_len  = (r_speed == lp_hs) ? f_add_sat(I_wait2) : w_fs_len;
                end
                S_RESET_SE0: if (w_expire) w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_speed <= lp_auto;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_load ? ((w_len == '0) ? '0 : w_len - lp_one) : (w_expire ? r_cnt : r_cnt - lp_one);
            r_error <= w_err;
            if (w_accept) r_speed <= I_speed;
        end
    end
    assign O_linestate = (r_state == S_ATTACH) ? ((r_speed == lp_ls) ? 2'b10 : 2'b01) :
                         (r_state == S_DONE && r_speed != lp_ls) ? 2'b01 : 2'b00;
    assign O_busy  = r_state == S_WAIT0 || r_state == S_ATTACH || r_state == S_RESET_SE0;
    assign O_done  = r_state == S_DONE;
    assign O_error = r_error;
endmodule
